branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch decision block for the pipelined core. It evaluates all six RV32I conditional-branch compares in EX and predicts fetch-stage direction from a 2-bit saturating branch history table (BHT). It registers the taken/redirect decision and counts mispredictions. It replaces the single-cycle `Branch & Zero` gating, which supported only BEQ and had no prediction.

## Interface
- XLEN, 32, operand width for compares
- PC_WIDTH, 32, program-counter width
- BHT_ENTRIES, 16, BHT depth; power of two, 2..256; IDX = log2(BHT_ENTRIES)
- CNT_WIDTH, 16, width of the misprediction counter

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- pred_pc  in  PC_WIDTH  fetch PC to predict
- pred_taken  out  1  combinational: MSB of BHT[pred_pc[IDX+1:2]]
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  decoder Branch control for the EX instruction
- ex_funct3  in  3  branch condition
- ex_rs1, ex_rs2  in  XLEN  compare operands, already forwarded
- ex_pc  in  PC_WIDTH  PC of the EX instruction
- ex_target  in  PC_WIDTH  branch target from the adder
- ex_pred_taken  in  1  prediction carried down with the instruction
- flush  in  1  squashes the EX instruction this cycle
- br_taken  out  1  registered: resolved branch was taken
- redirect  out  1  registered: misprediction; fetch must load redirect_pc
- redirect_pc  out  PC_WIDTH  registered correct next PC
- mispredict_cnt  out  CNT_WIDTH  saturating misprediction count

## Operation
- A resolve event occurs when ex_valid & ex_branch & !flush & the funct3 is legal.
- Legal funct3 values and taken conditions:
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed rs1<rs2
  - 101 BGE: signed rs1>=rs2
  - 110 BLTU: unsigned rs1<rs2
  - 111 BGEU: unsigned rs1>=rs2
- funct3 010 or 011: not a resolve event. No BHT update, no redirect, no count.
- Compares are full XLEN. Signed compares use two's-complement, so XLEN-1 is the sign bit.
- Actual outcome is `taken`. Mispredict = taken != ex_pred_taken.
- Correct PC is ex_target if taken, else ex_pc + 4, truncated to PC_WIDTH (wraps).
- BHT index for both lookup and update is pc[IDX+1:2].
- BHT counters are 2 bits:
  - 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Taken increments, saturating at 11. Not-taken decrements, saturating at 00.
- Lookup and update at the same index in the same cycle: pred_taken shows the pre-update value. There is no bypass.
- mispredict_cnt increments by 1 per mispredicting resolve event and holds at all-ones.

## Timing
- Reset (async, immediate):
  - br_taken=0, redirect=0, redirect_pc=0, mispredict_cnt=0.
  - Every BHT entry = 01, so pred_taken=0 for every PC.
- Reset asserted mid-operation discards any pending decision. The first redirect possible is one cycle after reset deasserts and a resolve event occurs.
- Latency is 1 cycle. A resolve event in cycle N gives br_taken/redirect/redirect_pc valid in cycle N+1. The BHT update is visible on pred_taken in cycle N+1.
- Without a resolve event in cycle N, br_taken=0 and redirect=0 in N+1. redirect_pc holds its last value.
- redirect is a single-cycle pulse per mispredicting event. Back-to-back events give back-to-back results, one per cycle.
- The pipeline must assert flush, or drop ex_valid, on the instruction in EX during the redirect cycle. This block does not self-squash.
- pred_taken is purely combinational from pred_pc and BHT state. It has no dependence on EX inputs within a cycle.

## Test plan
- Reset, then sweep pred_pc 0x0..0x3C -> pred_taken=0 everywhere. Outputs are 0 before the first clock edge.
- BEQ rs1=rs2=5, pc=0x100, target=0x140, ex_pred_taken=0 -> next cycle br_taken=1, redirect=1, redirect_pc=0x140, mispredict_cnt=1. Then pred_pc=0x100 gives pred_taken=1 (entry 10).
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1. BLT -> taken. BLTU -> not taken, with redirect_pc=pc+4 when predicted taken. BGE/BGEU give the complements.
- Saturation: four taken resolves at pc=0x200 -> entry 11. Then one not-taken -> 10, and pred_taken stays 1. Lookup of 0x200 in the update cycle shows the old value.
- Illegal funct3=010 with ex_branch=1, and also flush=1 on a legal branch -> no redirect, BHT and counter unchanged. Reset pulsed mid-sequence -> all state returns to reset values immediately.
- Build with CNT_WIDTH=2 and force 5 mispredicts -> mispredict_cnt sticks at 3. Build with BHT_ENTRIES=4: pc 0x0 and 0x10 alias the same entry.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Bus between the pipeline and branch_resolve_unit: fetch-side prediction lookup,
// EX-side resolve inputs and the registered redirect/statistics outputs.
interface branch_resolve_unit_if #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned CNT_WIDTH = 16
);
   logic [PC_WIDTH-1:0]  pred_pc;
   logic                 pred_taken;
   logic                 ex_valid;
   logic                 ex_branch;
   logic [2:0]           ex_funct3;
   logic [XLEN-1:0]      ex_rs1;
   logic [XLEN-1:0]      ex_rs2;
   logic [PC_WIDTH-1:0]  ex_pc;
   logic [PC_WIDTH-1:0]  ex_target;
   logic                 ex_pred_taken;
   logic                 flush;
   logic                 br_taken;
   logic                 redirect;
   logic [PC_WIDTH-1:0]  redirect_pc;
   logic [CNT_WIDTH-1:0] mispredict_cnt;

   modport master (
      output pred_pc, ex_valid, ex_branch, ex_funct3, ex_rs1, ex_rs2,
             ex_pc, ex_target, ex_pred_taken, flush,
      input  pred_taken, br_taken, redirect, redirect_pc, mispredict_cnt
   );

   modport slave (
      input  pred_pc, ex_valid, ex_branch, ex_funct3, ex_rs1, ex_rs2,
             ex_pc, ex_target, ex_pred_taken, flush,
      output pred_taken, br_taken, redirect, redirect_pc, mispredict_cnt
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I conditional branches in EX, predicts fetch direction from a
// 2-bit saturating BHT, registers the redirect decision and counts mispredicts.
module branch_resolve_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned BHT_ENTRIES = 16,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                clk,
   input  logic                reset,
   branch_resolve_unit_if.slave bus
);
   localparam int unsigned IDX = $clog2(BHT_ENTRIES);

   typedef enum logic [2:0] {
      COND_BEQ  = 3'b000,
      COND_BNE  = 3'b001,
      COND_BLT  = 3'b100,
      COND_BGE  = 3'b101,
      COND_BLTU = 3'b110,
      COND_BGEU = 3'b111
   } cond_e;

   logic [1:0]           bht [BHT_ENTRIES];
   logic [IDX-1:0]       pred_idx;
   logic [IDX-1:0]       upd_idx;
   logic                 eq;
   logic                 lt_s;
   logic                 lt_u;
   logic                 legal;
   logic                 taken;
   logic                 resolve;
   logic                 mispredict;
   logic [PC_WIDTH-1:0]  next_pc;
   logic [1:0]           ctr_cur;
   logic [1:0]           ctr_next;
   logic                 br_taken_q;
   logic                 redirect_q;
   logic [PC_WIDTH-1:0]  redirect_pc_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 unused_pred_pc_bits;

   // Lookup reads the array directly: a same-index update lands only at the edge.
   assign pred_idx       = bus.pred_pc[IDX+1:2];
   assign bus.pred_taken = bht[pred_idx][1];

   assign unused_pred_pc_bits = ^{bus.pred_pc[PC_WIDTH-1:IDX+2], bus.pred_pc[1:0]};

   assign eq   = (bus.ex_rs1 == bus.ex_rs2);
   assign lt_s = ($signed(bus.ex_rs1) < $signed(bus.ex_rs2));
   assign lt_u = (bus.ex_rs1 < bus.ex_rs2);

   always_comb begin
      legal = 1'b1;
      taken = 1'b0;
      case (cond_e'(bus.ex_funct3))
         COND_BEQ:  taken = eq;
         COND_BNE:  taken = !eq;
         COND_BLT:  taken = lt_s;
         COND_BGE:  taken = !lt_s;
         COND_BLTU: taken = lt_u;
         COND_BGEU: taken = !lt_u;
         default:   legal = 1'b0;
      endcase
   end

   assign resolve    = bus.ex_valid & bus.ex_branch & !bus.flush & legal;
   assign mispredict = (taken != bus.ex_pred_taken);
   assign next_pc    = taken ? bus.ex_target : (bus.ex_pc + PC_WIDTH'(4));
   assign upd_idx    = bus.ex_pc[IDX+1:2];
   assign ctr_cur    = bht[upd_idx];

   always_comb begin
      ctr_next = ctr_cur;
      if (taken) begin
         if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else if (resolve) begin
         bht[upd_idx] <= ctr_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         br_taken_q    <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         cnt_q         <= '0;
      end else begin
         br_taken_q <= resolve & taken;
         redirect_q <= resolve & mispredict;
         if (resolve) redirect_pc_q <= next_pc;
         if (resolve && mispredict && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign bus.br_taken       = br_taken_q;
   assign bus.redirect       = redirect_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: default build plus CNT_WIDTH=2 and
// BHT_ENTRIES=4 builds driven in lockstep, checked against a reference model.
module tb_branch_resolve_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   branch_resolve_unit_if #(.XLEN(32), .PC_WIDTH(32), .CNT_WIDTH(16)) if_m ();
   branch_resolve_unit_if #(.XLEN(32), .PC_WIDTH(32), .CNT_WIDTH(2))  if_c ();
   branch_resolve_unit_if #(.XLEN(32), .PC_WIDTH(32), .CNT_WIDTH(16)) if_b ();

   branch_resolve_unit #(.XLEN(32), .PC_WIDTH(32), .BHT_ENTRIES(16), .CNT_WIDTH(16))
      dut_m (.clk(clk), .reset(reset), .bus(if_m));
   branch_resolve_unit #(.XLEN(32), .PC_WIDTH(32), .BHT_ENTRIES(16), .CNT_WIDTH(2))
      dut_c (.clk(clk), .reset(reset), .bus(if_c));
   branch_resolve_unit #(.XLEN(32), .PC_WIDTH(32), .BHT_ENTRIES(4), .CNT_WIDTH(16))
      dut_b (.clk(clk), .reset(reset), .bus(if_b));

   assign if_c.pred_pc = if_m.pred_pc;       assign if_b.pred_pc = if_m.pred_pc;
   assign if_c.ex_valid = if_m.ex_valid;     assign if_b.ex_valid = if_m.ex_valid;
   assign if_c.ex_branch = if_m.ex_branch;   assign if_b.ex_branch = if_m.ex_branch;
   assign if_c.ex_funct3 = if_m.ex_funct3;   assign if_b.ex_funct3 = if_m.ex_funct3;
   assign if_c.ex_rs1 = if_m.ex_rs1;         assign if_b.ex_rs1 = if_m.ex_rs1;
   assign if_c.ex_rs2 = if_m.ex_rs2;         assign if_b.ex_rs2 = if_m.ex_rs2;
   assign if_c.ex_pc = if_m.ex_pc;           assign if_b.ex_pc = if_m.ex_pc;
   assign if_c.ex_target = if_m.ex_target;   assign if_b.ex_target = if_m.ex_target;
   assign if_c.ex_pred_taken = if_m.ex_pred_taken;
   assign if_b.ex_pred_taken = if_m.ex_pred_taken;
   assign if_c.flush = if_m.flush;           assign if_b.flush = if_m.flush;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        ptk;
      logic        tk;
   } vec_t;

   typedef struct {
      logic        br;
      logic        rd;
      logic [31:0] rpc;
      int unsigned cnt;
   } exp_t;

   int errors = 0;
   int checks = 0;
   vec_t vt[14];
   exp_t sbq[$];
   logic [1:0] bht_m[16];
   logic [1:0] bht_b[4];
   int unsigned cnt_m;
   logic [31:0] rpc_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] sat(input logic [1:0] c, input logic tk);
      if (tk) return (c == 2'd3) ? 2'd3 : c + 2'd1;
      return (c == 2'd0) ? 2'd0 : c - 2'd1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
      for (int i = 0; i < 4; i++) bht_b[i] = 2'b01;
      cnt_m = 0;
      rpc_m = '0;
      sbq.delete();
   endtask

   task automatic chk_pred(input logic [31:0] pc);
      if_m.pred_pc = pc;
      #1;
      chk("pred_taken", {31'd0, if_m.pred_taken}, {31'd0, bht_m[pc[5:2]][1]});
      chk("pred_taken_bht4", {31'd0, if_b.pred_taken}, {31'd0, bht_b[pc[3:2]][1]});
   endtask

   // Drives one EX cycle, checks the lookup still shows pre-update state,
   // queues the expected registered outputs and compares them after the edge.
   task automatic drive(input logic v, input logic br, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic ptk, input logic fl, input logic tk);
      exp_t e, got;
      logic res;
      if_m.ex_valid = v;  if_m.ex_branch = br; if_m.ex_funct3 = f3;
      if_m.ex_rs1 = a;    if_m.ex_rs2 = b;     if_m.ex_pc = pc;
      if_m.ex_target = tgt; if_m.ex_pred_taken = ptk; if_m.flush = fl;
      #1;
      chk("pred_same_cycle", {31'd0, if_m.pred_taken}, {31'd0, bht_m[if_m.pred_pc[5:2]][1]});
      res = v && br && !fl && (f3 != 3'b010) && (f3 != 3'b011);
      e.br = res && tk;
      e.rd = res && (tk != ptk);
      if (res) begin
         rpc_m = tk ? tgt : pc + 32'd4;
         bht_m[pc[5:2]] = sat(bht_m[pc[5:2]], tk);
         bht_b[pc[3:2]] = sat(bht_b[pc[3:2]], tk);
         if (e.rd && cnt_m != 32'hFFFF) cnt_m++;
      end
      e.rpc = rpc_m;
      e.cnt = cnt_m;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      chk("br_taken", {31'd0, if_m.br_taken}, {31'd0, got.br});
      chk("redirect", {31'd0, if_m.redirect}, {31'd0, got.rd});
      chk("redirect_pc", if_m.redirect_pc, got.rpc);
      chk("mispredict_cnt", {16'd0, if_m.mispredict_cnt}, got.cnt);
      chk("mispredict_cnt_w2", {30'd0, if_c.mispredict_cnt},
          (got.cnt > 3) ? 32'd3 : got.cnt);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      vt[0]  = '{3'b000, 32'd5,        32'd5,        32'h100,      32'h140, 1'b0, 1'b1};
      vt[1]  = '{3'b100, 32'hFFFFFFFF, 32'd1,        32'h304,      32'h344, 1'b0, 1'b1};
      vt[2]  = '{3'b110, 32'hFFFFFFFF, 32'd1,        32'h308,      32'h348, 1'b1, 1'b0};
      vt[3]  = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'h30C,      32'h34C, 1'b1, 1'b0};
      vt[4]  = '{3'b111, 32'hFFFFFFFF, 32'd1,        32'h310,      32'h350, 1'b0, 1'b1};
      vt[5]  = '{3'b001, 32'd5,        32'd5,        32'h314,      32'h354, 1'b0, 1'b0};
      vt[6]  = '{3'b001, 32'd0,        32'd1,        32'h318,      32'h358, 1'b1, 1'b1};
      vt[7]  = '{3'b000, 32'h80000000, 32'd0,        32'h31C,      32'h35C, 1'b1, 1'b0};
      vt[8]  = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h320,      32'h360, 1'b0, 1'b1};
      vt[9]  = '{3'b101, 32'd7,        32'd7,        32'h324,      32'h364, 1'b1, 1'b1};
      vt[10] = '{3'b111, 32'd7,        32'd7,        32'h328,      32'h368, 1'b0, 1'b1};
      vt[11] = '{3'b110, 32'd0,        32'd0,        32'h32C,      32'h36C, 1'b0, 1'b0};
      vt[12] = '{3'b100, 32'h7FFFFFFF, 32'h80000000, 32'h330,      32'h370, 1'b1, 1'b0};
      vt[13] = '{3'b000, 32'd1,        32'd2,        32'hFFFFFFFC, 32'h400, 1'b1, 1'b0};

      if_m.pred_pc = '0; if_m.ex_valid = 1'b0; if_m.ex_branch = 1'b0;
      if_m.ex_funct3 = '0; if_m.ex_rs1 = '0; if_m.ex_rs2 = '0; if_m.ex_pc = '0;
      if_m.ex_target = '0; if_m.ex_pred_taken = 1'b0; if_m.flush = 1'b0;
      model_reset();

      #1 reset = 1'b1;
      #1;
      chk("rst_br_taken", {31'd0, if_m.br_taken}, 32'd0);
      chk("rst_redirect", {31'd0, if_m.redirect}, 32'd0);
      chk("rst_redirect_pc", if_m.redirect_pc, 32'd0);
      chk("rst_cnt", {16'd0, if_m.mispredict_cnt}, 32'd0);
      for (int p = 0; p <= 'h3C; p += 4) begin
         if_m.pred_pc = p;
         #1;
         chk("rst_pred_sweep", {31'd0, if_m.pred_taken}, 32'd0);
      end
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         drive(1'b1, 1'b1, vt[i].f3, vt[i].a, vt[i].b, vt[i].pc, vt[i].tgt,
               vt[i].ptk, 1'b0, vt[i].tk);
         if (i == 0) begin
            chk("beq_cnt_one", {16'd0, if_m.mispredict_cnt}, 32'd1);
            chk("beq_redirect_pc", if_m.redirect_pc, 32'h140);
            if_m.pred_pc = 32'h100;
            #1;
            chk("beq_pred_after", {31'd0, if_m.pred_taken}, 32'd1);
         end
      end
      chk("wrap_redirect_pc", if_m.redirect_pc, 32'h0);
      idle();
      for (int p = 0; p <= 'h3C; p += 4) chk_pred(p);

      // Illegal funct3, flush, invalid and non-branch: none may resolve.
      if_m.pred_pc = 32'h33C;
      drive(1'b1, 1'b1, 3'b010, 32'd5, 32'd5, 32'h33C, 32'h500, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 3'b011, 32'd5, 32'd6, 32'h33C, 32'h500, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 3'b000, 32'd5, 32'd5, 32'h33C, 32'h500, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 3'b000, 32'd5, 32'd5, 32'h33C, 32'h500, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 3'b000, 32'd5, 32'd5, 32'h33C, 32'h500, 1'b0, 1'b0, 1'b1);
      chk_pred(32'h33C);

      // Async reset with a mispredict pending on the EX inputs.
      drive(1'b1, 1'b1, 3'b000, 32'd9, 32'd9, 32'h100, 32'h180, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      #1;
      chk("midrst_redirect", {31'd0, if_m.redirect}, 32'd0);
      chk("midrst_br_taken", {31'd0, if_m.br_taken}, 32'd0);
      chk("midrst_redirect_pc", if_m.redirect_pc, 32'd0);
      chk("midrst_cnt", {16'd0, if_m.mispredict_cnt}, 32'd0);
      if_m.pred_pc = 32'h100;
      #1;
      chk("midrst_pred", {31'd0, if_m.pred_taken}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_held_redirect", {31'd0, if_m.redirect}, 32'd0);
      reset = 1'b0;
      model_reset();
      idle();

      // Saturation at 0x200, lookup of the same index during each update.
      if_m.pred_pc = 32'h200;
      for (int k = 0; k < 4; k++)
         drive(1'b1, 1'b1, 3'b001, 32'd1, 32'd2, 32'h200, 32'h280, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 3'b001, 32'd3, 32'd3, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0);
      #1;
      chk("sat_pred_still_taken", {31'd0, if_m.pred_taken}, 32'd1);
      chk_pred(32'h200);

      // Mispredict burst drives the 2-bit counter into saturation.
      for (int k = 0; k < 6; k++)
         drive(1'b1, 1'b1, 3'b000, 32'd4, 32'd4, 32'h44, 32'h80, 1'b0, 1'b0, 1'b1);
      chk("cnt_w2_sticks", {30'd0, if_c.mispredict_cnt}, 32'd3);

      // pc 0x0 and 0x10 share an entry only in the 4-entry build.
      for (int k = 0; k < 3; k++)
         drive(1'b1, 1'b1, 3'b110, 32'd9, 32'd2, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0);
      chk_pred(32'h10);
      for (int k = 0; k < 2; k++)
         drive(1'b1, 1'b1, 3'b110, 32'd1, 32'd2, 32'h0, 32'h40, 1'b1, 1'b0, 1'b1);
      chk_pred(32'h10);
      chk_pred(32'h0);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
